inert_seq_rdr: RTL
==================

// Module: inert_seq_rdr
// PURPOSE
//  Parametrised sequencer between inertial sensor interrupt and the SPI_mnrch master (snd/cmd/done/resp).
//  Runs a configurable init-write list after power-up, then on each data-ready INT reads NUM_CH 16-bit
//  channels as low/high byte pairs. Publishes all channels atomically with a one-cycle vld.
//  Adds an INT watchdog with auto re-init and an overrun counter. Feeds inertial_integrator and other consumers.
// PARAMETERS
//  NUM_CH       4                          channels read per sample (1..8)
//  NUM_INIT     4                          init write commands (1..8)
//  INIT_CMDS    {16'h1460,16'h1150,16'h1053,16'h0D02}  packed; entry 0 in LSBs is sent first
//  CH_ADDR      {8'h2C,8'h2A,8'h26,8'h24}  packed low-byte reg addr per channel, ch0 in LSBs; high byte = addr+1
//  PWR_UP_BITS  16                         power-up wait = 2^PWR_UP_BITS cycles
//  TMO_BITS     20                         INT watchdog = 2^TMO_BITS cycles
// PORTS
//  clk      in   1           system clock
//  rst_n    in   1           synchronous active-low reset
//  INT      in   1           sensor data-ready, asynchronous, active high
//  done     in   1           SPI_mnrch transaction complete, 1-cycle pulse
//  resp     in   16          SPI_mnrch response; only [7:0] used
//  snd      out  1           start SPI transaction, 1-cycle pulse, registered
//  cmd      out  16          SPI command, registered, stable from snd until next snd
//  data     out  NUM_CH*16   channel words, ch0 in LSBs, {high,low}
//  vld      out  1           1-cycle pulse: data just updated
//  init_ok  out  1           high while in IDLE/READ (init list completed)
//  tmo      out  1           sticky: watchdog fired since reset
//  ovr_cnt  out  8           saturating count of INT rising edges seen during READ
// BEHAVIOUR
//  Reset (rst_n low at posedge): state=PWRUP; snd=0, cmd=0, data=0, vld=0, init_ok=0, tmo=0, ovr_cnt=0;
//   counters, indices and shadow cleared. Reset mid-transaction abandons it; late done is ignored.
//  INT is double-flopped (INT_s); INT_s rising edge = INT_s & ~INT_s_prev.
//  PWRUP: counter increments; when all ones, next cycle snd=1, cmd=INIT_CMDS[0], go INIT, idx=0.
//  INIT: on done, if idx<NUM_INIT-1: idx++, next cycle snd=1 with cmd=INIT_CMDS[idx+1];
//   else go IDLE (no snd). INT ignored in PWRUP/INIT.
//  IDLE: init_ok=1. If INT_s=1: next cycle snd=1, cmd={1'b1,CH_ADDR[0][6:0],8'h00}, go READ, rd=0.
//   Watchdog counts cycles in IDLE with INT_s=0, clears on INT_s=1 or IDLE entry. At all ones:
//   tmo<=1, idx=0, go INIT and resend list (no power-up wait); next cycle snd with INIT_CMDS[0].
//  READ: rd runs 0..2*NUM_CH-1; ch=rd>>1, byte=rd[0]; cmd={1'b1,(CH_ADDR[ch]+byte)[6:0],8'h00}.
//   On done: shadow[rd*8+:8]<=resp[7:0]; if rd<last, rd++ and snd next cycle with next cmd;
//   if last, next cycle data<=shadow (incl. final byte), vld=1 for one cycle, go IDLE.
//   data never changes except on that cycle. Each INT_s rising edge in READ increments ovr_cnt (sat 255).
//  done outside INIT/READ, or while snd high, is ignored. snd never asserts two consecutive cycles.
//  Latency: done -> next snd = 1 cycle; last done -> vld = 1 cycle.
//  Address add is 8-bit, wraps mod 256; bit 7 of cmd always forced to 1 for reads, untouched for init.
// TESTING
//  PWR_UP_BITS=4: release reset -> snd at cycle 16, cmd 0D02; done pulses -> cmds 1053,1150,1460, then init_ok=1.
//  Default params, INT high, resp low bytes 11,22..88 -> cmds A4,A5,A6,A7,AA,AB,AC,AD; data=64'h8877_6655_4433_2211, one vld.
//  Mid-read data held at previous sample value; vld never high except after 8th done.
//  3 INT pulses during one READ -> ovr_cnt=3; 300 pulses -> ovr_cnt=255.
//  TMO_BITS=6, INT low in IDLE 64 cycles -> tmo=1, init_ok=0, snd with cmd 0D02; list re-runs.
//  rst_n low during READ rd=3 -> all outputs 0, PWRUP restart; NUM_CH=1 -> only A4,A5 read.

Source files
------------

// File: rtl/inert_seq_rdr.sv
// inert_seq_rdr: sequences SPI_mnrch transactions for an inertial sensor.
// After a power-up wait it writes an init command list, then on each data-ready
// INT reads NUM_CH 16-bit channels (low byte, then high byte) and publishes them
// all at once with a one-cycle vld. An INT watchdog re-runs the init list, and
// INT edges that arrive mid-read are counted in a saturating overrun counter.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   INT          sensor data-ready (asynchronous, active high)
//   done, resp   SPI transaction complete pulse and response (resp[7:0] used)
//   snd, cmd     SPI start pulse and command word
//   data, vld    channel words (ch0 in LSBs, {high,low}) and update pulse
//   init_ok      init list completed (IDLE/READ)
//   tmo          sticky watchdog flag
//   ovr_cnt      saturating count of INT edges seen during a read
module inert_seq_rdr #(
   parameter int unsigned             NUM_CH      = 4,
   parameter int unsigned             NUM_INIT    = 4,
   parameter logic [NUM_INIT*16-1:0]  INIT_CMDS   = {16'h1460, 16'h1150, 16'h1053, 16'h0D02},
   parameter logic [NUM_CH*8-1:0]     CH_ADDR     = {8'h2C, 8'h2A, 8'h26, 8'h24},
   parameter int unsigned             PWR_UP_BITS = 16,
   parameter int unsigned             TMO_BITS    = 20
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   INT,
   input  logic                   done,
   input  logic [15:0]            resp,
   output logic                   snd,
   output logic [15:0]            cmd,
   output logic [NUM_CH*16-1:0]   data,
   output logic                   vld,
   output logic                   init_ok,
   output logic                   tmo,
   output logic [7:0]             ovr_cnt
);

   localparam int unsigned NUM_RD = 2 * NUM_CH;
   localparam int unsigned RD_W   = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
   localparam int unsigned IDX_W  = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;
   localparam logic [RD_W-1:0]  LAST_RD  = RD_W'(NUM_RD - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INIT - 1);

   typedef enum logic [1:0] {ST_PWRUP, ST_INIT, ST_IDLE, ST_READ} state_t;

   state_t                  r_state;
   logic [PWR_UP_BITS-1:0]  r_pu_cnt;
   logic [TMO_BITS-1:0]     r_wd_cnt;
   logic [IDX_W-1:0]        r_idx;
   logic [RD_W-1:0]         r_rd;
   logic [NUM_RD*8-1:0]     r_shadow;
   logic                    r_int_m;
   logic                    r_int_s;
   logic                    r_int_p;
   logic                    r_snd;
   logic [15:0]             r_cmd;
   logic [NUM_CH*16-1:0]    r_data;
   logic                    r_vld;
   logic                    r_init_ok;
   logic                    r_tmo;
   logic [7:0]              r_ovr;

   logic                    w_int_rise;
   logic                    w_done_ok;
   logic [15:0]             w_init_nx;
   logic [NUM_RD*8-1:0]     w_shadow;
   logic                    w_unused_resp_hi;

   // Read command for byte rd: channel address plus byte offset, read bit forced.
   function automatic logic [15:0] rd_cmd(input logic [RD_W-1:0] rd);
      logic [7:0] a;
      a = CH_ADDR[32'(rd >> 1) * 32'd8 +: 8] + 8'(rd[0]);
      return 16'h8000 | {a, 8'h00};
   endfunction

   assign w_int_rise       = r_int_s & ~r_int_p;
   // A done that overlaps our own snd cannot belong to the command just issued.
   assign w_done_ok        = done & ~r_snd;
   assign w_init_nx        = INIT_CMDS[(32'(r_idx) + 32'd1) * 32'd16 +: 16];
   assign w_unused_resp_hi = ^resp[15:8];

   // Shadow with the incoming byte merged, so the last byte reaches data directly.
   always_comb begin
      w_shadow = r_shadow;
      w_shadow[32'(r_rd) * 32'd8 +: 8] = resp[7:0];
   end

   // Sequencer state, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_PWRUP;
         r_pu_cnt  <= '0;
         r_wd_cnt  <= '0;
         r_idx     <= '0;
         r_rd      <= '0;
         r_shadow  <= '0;
         r_int_m   <= 1'b0;
         r_int_s   <= 1'b0;
         r_int_p   <= 1'b0;
         r_snd     <= 1'b0;
         r_cmd     <= '0;
         r_data    <= '0;
         r_vld     <= 1'b0;
         r_init_ok <= 1'b0;
         r_tmo     <= 1'b0;
         r_ovr     <= '0;
      end else begin
         r_int_m <= INT;
         r_int_s <= r_int_m;
         r_int_p <= r_int_s;
         r_snd   <= 1'b0;
         r_vld   <= 1'b0;

         if (r_state == ST_READ && w_int_rise && r_ovr != 8'hFF)
            r_ovr <= r_ovr + 8'd1;

         case (r_state)
            ST_PWRUP: begin
               if (&r_pu_cnt) begin
                  r_snd   <= 1'b1;
                  r_cmd   <= INIT_CMDS[15:0];
                  r_idx   <= '0;
                  r_state <= ST_INIT;
               end else begin
                  r_pu_cnt <= r_pu_cnt + PWR_UP_BITS'(1);
               end
            end
            ST_INIT: begin
               if (w_done_ok) begin
                  if (r_idx != LAST_IDX) begin
                     r_idx <= r_idx + IDX_W'(1);
                     r_snd <= 1'b1;
                     r_cmd <= w_init_nx;
                  end else begin
                     r_state   <= ST_IDLE;
                     r_init_ok <= 1'b1;
                     r_wd_cnt  <= '0;
                  end
               end
            end
            ST_IDLE: begin
               if (r_int_s) begin
                  r_snd    <= 1'b1;
                  r_cmd    <= rd_cmd('0);
                  r_rd     <= '0;
                  r_wd_cnt <= '0;
                  r_state  <= ST_READ;
               end else if (&r_wd_cnt) begin
                  // Sensor went quiet: re-run the init list without the power-up wait.
                  r_tmo     <= 1'b1;
                  r_init_ok <= 1'b0;
                  r_idx     <= '0;
                  r_snd     <= 1'b1;
                  r_cmd     <= INIT_CMDS[15:0];
                  r_state   <= ST_INIT;
               end else begin
                  r_wd_cnt <= r_wd_cnt + TMO_BITS'(1);
               end
            end
            ST_READ: begin
               if (w_done_ok) begin
                  r_shadow <= w_shadow;
                  if (r_rd != LAST_RD) begin
                     r_rd  <= r_rd + RD_W'(1);
                     r_snd <= 1'b1;
                     r_cmd <= rd_cmd(r_rd + RD_W'(1));
                  end else begin
                     r_data   <= w_shadow;
                     r_vld    <= 1'b1;
                     r_wd_cnt <= '0;
                     r_state  <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_PWRUP;
         endcase
      end
   end

   assign snd     = r_snd;
   assign cmd     = r_cmd;
   assign data    = r_data;
   assign vld     = r_vld;
   assign init_ok = r_init_ok;
   assign tmo     = r_tmo;
   assign ovr_cnt = r_ovr;

endmodule
